regfile_wb_arbiter: RTL and testbench

//  Shares the single register-file write port (we/rd/wdata) between two writeback

---
 rtl/regfile_wb_arbiter.sv | 103 ++++++++++
 tb/tb_regfile_wb_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter for the register-file write port.
// Two requesters share one registered stage with hold, x0 filter and RAW flags.
module regfile_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_rd,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_rd,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  input  logic              hold,
  input  logic [ADDR_W-1:0] chk_rs1,
  input  logic [ADDR_W-1:0] chk_rs2,
  output logic              haz_rs1,
  output logic              haz_rs2,
  output logic              we,
  output logic [ADDR_W-1:0] rd,
  output logic [DATA_W-1:0] wdata,
  output logic [CNT_W-1:0]  wr_count
);

  logic              st_valid;
  logic [ADDR_W-1:0] st_rd;
  logic [DATA_W-1:0] st_data;
  logic              last_gnt;

  logic              can_accept;
  logic              gnt0;
  logic              gnt1;
  logic              gnt;
  logic              gnt_idx;
  logic [ADDR_W-1:0] g_rd;
  logic [DATA_W-1:0] g_data;
  logic              load;

  // Stage drains and refills in one cycle, so only a held full stage blocks.
  always_comb begin
    can_accept = (~st_valid | ~hold) & ~reset;
    gnt0 = can_accept & req0_valid
         & (~req1_valid | last_gnt);
    gnt1 = can_accept & req1_valid
         & (~req0_valid | ~last_gnt);
    gnt     = gnt0 | gnt1;
    gnt_idx = 1'b0;
    g_rd    = '0;
    g_data  = '0;
    unique case (1'b1)
      gnt0: begin
        g_rd   = req0_rd;
        g_data = req0_wdata;
      end
      gnt1: begin
        gnt_idx = 1'b1;
        g_rd    = req1_rd;
        g_data  = req1_wdata;
      end
      default: ;
    endcase
    load = gnt & (g_rd != '0);
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  assign we    = st_valid & ~hold;
  assign rd    = st_rd;
  assign wdata = st_data;

  assign haz_rs1 = st_valid & (st_rd == chk_rs1)
                 & (chk_rs1 != '0);
  assign haz_rs2 = st_valid & (st_rd == chk_rs2)
                 & (chk_rs2 != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_valid <= 1'b0;
      st_rd    <= '0;
      st_data  <= '0;
      last_gnt <= 1'b1;
      wr_count <= '0;
    end else begin
      if (gnt)
        last_gnt <= gnt_idx;
      if (load) begin
        st_valid <= 1'b1;
        st_rd    <= g_rd;
        st_data  <= g_data;
      end else if (~hold) begin
        st_valid <= 1'b0;
      end
      wr_count <= wr_count
                + {{(CNT_W-1){1'b0}}, we};
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter.
// Vector table plus reset and counter-wrap sequences.
module tb_regfile_wb_arbiter;

  logic        clk;
  logic        reset;
  logic        req0_valid;
  logic [4:0]  req0_rd;
  logic [31:0] req0_wdata;
  logic        req0_ready;
  logic        req1_valid;
  logic [4:0]  req1_rd;
  logic [31:0] req1_wdata;
  logic        req1_ready;
  logic        hold;
  logic [4:0]  chk_rs1;
  logic [4:0]  chk_rs2;
  logic        haz_rs1;
  logic        haz_rs2;
  logic        we;
  logic [4:0]  rd;
  logic [31:0] wdata;
  logic [15:0] wr_count;

  int nvec  = 0;
  int nfail = 0;

  regfile_wb_arbiter #(
    .DATA_W(32), .ADDR_W(5), .CNT_W(16)
  ) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_rd(req0_rd),
    .req0_wdata(req0_wdata), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_rd(req1_rd),
    .req1_wdata(req1_wdata), .req1_ready(req1_ready),
    .hold(hold), .chk_rs1(chk_rs1), .chk_rs2(chk_rs2),
    .haz_rs1(haz_rs1), .haz_rs2(haz_rs2),
    .we(we), .rd(rd), .wdata(wdata),
    .wr_count(wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v0;
    logic [4:0]  rd0;
    logic [31:0] d0;
    logic        v1;
    logic [4:0]  rd1;
    logic [31:0] d1;
    logic        hold;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [57:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    input logic v0, input logic [4:0] rd0,
    input logic [31:0] d0,
    input logic v1, input logic [4:0] rd1,
    input logic [31:0] d1,
    input logic h, input logic [4:0] s1,
    input logic [4:0] s2,
    input logic r0, input logic r1,
    input logic w, input logic [4:0] ra,
    input logic [31:0] wd,
    input logic h1, input logic h2,
    input logic [15:0] cnt);
    vec_t t;
    t.v0 = v0; t.rd0 = rd0; t.d0 = d0;
    t.v1 = v1; t.rd1 = rd1; t.d1 = d1;
    t.hold = h; t.rs1 = s1; t.rs2 = s2;
    t.exp = {r0, r1, w, ra, wd, h1, h2, cnt};
    return t;
  endfunction

  function automatic logic [57:0] outs();
    return {req0_ready, req1_ready, we, rd, wdata,
            haz_rs1, haz_rs2, wr_count};
  endfunction

  task automatic chk(input string nm,
                     input logic [63:0] a,
                     input logic [63:0] e);
    nvec++;
    if (a !== e) begin
      nfail++;
      $display("FAIL %s: got %h expected %h",
               nm, a, e);
    end
  endtask

  task automatic drive(input vec_t t);
    req0_valid = t.v0; req0_rd = t.rd0;
    req0_wdata = t.d0;
    req1_valid = t.v1; req1_rd = t.rd1;
    req1_wdata = t.d1;
    hold = t.hold; chk_rs1 = t.rs1;
    chk_rs2 = t.rs2;
  endtask

  task automatic idle();
    req0_valid = 0; req0_rd = 0; req0_wdata = 0;
    req1_valid = 0; req1_rd = 0; req1_wdata = 0;
    hold = 0; chk_rs1 = 0; chk_rs2 = 0;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    tbl.push_back(mk(0,0,0, 0,0,0, 0,0,0,
      0,0,0,0,0,0,0,0));
    tbl.push_back(mk(1,5,32'hDEADBEEF, 0,0,0, 0,5,0,
      1,0,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0, 0,0,0, 0,5,0,
      0,0,1,5,32'hDEADBEEF,1,0,0));
    tbl.push_back(mk(1,1,32'h11, 1,2,32'h22, 0,0,0,
      0,1,0,5,32'hDEADBEEF,0,0,1));
    tbl.push_back(mk(1,1,32'h11, 1,3,32'h33, 0,0,0,
      1,0,1,2,32'h22,0,0,1));
    tbl.push_back(mk(1,4,32'h44, 1,3,32'h33, 0,0,0,
      0,1,1,1,32'h11,0,0,2));
    tbl.push_back(mk(1,4,32'h44, 0,0,0, 0,0,0,
      1,0,1,3,32'h33,0,0,3));
    tbl.push_back(mk(0,0,0, 1,0,32'h1234, 0,0,0,
      0,1,1,4,32'h44,0,0,4));
    tbl.push_back(mk(0,0,0, 0,0,0, 0,4,0,
      0,0,0,4,32'h44,0,0,5));
    tbl.push_back(mk(1,7,32'h77, 0,0,0, 0,0,0,
      1,0,0,4,32'h44,0,0,5));
    for (int k = 0; k < 3; k++)
      tbl.push_back(mk(1,8,32'h88, 0,0,0, 1,7,0,
        0,0,0,7,32'h77,1,0,5));
    tbl.push_back(mk(1,8,32'h88, 0,0,0, 0,7,0,
      1,0,1,7,32'h77,1,0,5));
    tbl.push_back(mk(0,0,0, 0,0,0, 1,7,8,
      0,0,0,8,32'h88,0,1,6));
    tbl.push_back(mk(0,0,0, 0,0,0, 0,0,0,
      0,0,1,8,32'h88,0,0,6));
    tbl.push_back(mk(0,0,0, 1,9,32'h99, 1,0,0,
      0,1,0,8,32'h88,0,0,7));
    tbl.push_back(mk(0,0,0, 0,0,0, 0,0,0,
      0,0,1,9,32'h99,0,0,7));
    tbl.push_back(mk(0,0,0, 0,0,0, 0,0,0,
      0,0,0,9,32'h99,0,0,8));

    // reset state, with a requester already pending
    @(negedge clk);
    req0_valid = 1; req0_rd = 3;
    req1_valid = 1; req1_rd = 4;
    #1;
    chk("rst_ready0", req0_ready, 0);
    chk("rst_ready1", req1_ready, 0);
    chk("rst_we", we, 0);
    chk("rst_cnt", wr_count, 0);
    @(negedge clk);
    idle();
    reset = 1'b0;

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i]);
      #1;
      chk($sformatf("vec%0d", i), outs(), tbl[i].exp);
    end

    // reset while a write is staged
    @(negedge clk);
    idle();
    req0_valid = 1; req0_rd = 6;
    req0_wdata = 32'h66;
    @(negedge clk);
    idle();
    chk_rs1 = 6;
    #1;
    chk("pre_rst_we", we, 1);
    chk("pre_rst_rd", rd, 6);
    #1 reset = 1'b1;
    req0_valid = 1; req0_rd = 6;
    #1;
    chk("mid_rst_we", we, 0);
    chk("mid_rst_cnt", wr_count, 0);
    chk("mid_rst_haz", haz_rs1, 0);
    chk("mid_rst_rdy", req0_ready, 0);
    @(negedge clk);
    idle();
    reset = 1'b0;
    @(negedge clk);
    #1;
    chk("post_rst_we", we, 0);
    chk("post_rst_cnt", wr_count, 0);

    // sustained writes until the counter wraps
    req0_valid = 1; req0_rd = 1;
    req0_wdata = 32'hA5A5;
    for (int c = 0;
         c < 70000 && wr_count != 16'hFFFF; c++)
      @(negedge clk);
    #1;
    chk("wrap_max", wr_count, 16'hFFFF);
    chk("wrap_we", we, 1);
    @(negedge clk);
    #1;
    chk("wrap_zero", wr_count, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nfail);
    $finish;
  end

endmodule
